// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback slice.
// The data width comes from the global XLEN macro; a 32-bit default is
// supplied here for stand-alone builds.
`ifndef XLEN
`define XLEN 32
`endif

package wb_pkg;

  // Default number of buffered coprocessor results
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // x0 is hardwired to zero, so writes to it are never performed
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]        rd;
    logic [`XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Coprocessor result handshake (valid/ready with destination and data).
// Ports:
//   master modport - coprocessor side, drives valid/rd/data, sees ready
//   slave  modport - writeback side, drives ready
`ifndef XLEN
`define XLEN 32
`endif

interface regfile_writeback_if;
  logic              cop_res_valid;
  logic              cop_res_ready;
  logic [4:0]        cop_res_rd;
  logic [`XLEN-1:0]  cop_res_data;

  modport master (
    output cop_res_valid,
    output cop_res_rd,
    output cop_res_data,
    input  cop_res_ready
  );

  modport slave (
    input  cop_res_valid,
    input  cop_res_rd,
    input  cop_res_data,
    output cop_res_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of wb_entry_t used to buffer coprocessor results.
// Ports:
//   clock, reset       - clock, synchronous active-low reset
//   push, push_entry   - write request (ignored when full)
//   pop, head_entry    - read request (ignored when empty), current head
//   full, empty, count - occupancy status from the registered count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head_entry,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_entry = mem[rd_ptr];

  // Storage needs no reset: entries are only read once count says valid
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap modulo DEPTH through natural PTR_W-bit overflow
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage in front of the register file write port. Core results
// always win; coprocessor results are buffered in a FIFO and drained on
// idle core cycles. A busy scoreboard flags reads of registers still
// waiting for a coprocessor result.
// Optional feature macro: WB_BYPASS_EN - a coprocessor result arriving on
// an idle core cycle with an empty FIFO goes straight to the output
// register instead of through the FIFO.
// Ports:
//   clock, reset                       - clock, synchronous active-low reset
//   core_wb_valid/rd/data              - single-cycle core result
//   cop_issue_valid/rd                 - marks a destination pending
//   cop_res (slave)                    - coprocessor result handshake
//   rs1_address, rs2_address, hazard   - decoder hazard query
//   rf_write_enable/rd_address/rd_data - register file write port
//   fifo_count                         - buffered result count
`ifndef XLEN
`define XLEN 32
`endif

module regfile_writeback
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         core_wb_valid,
  input  logic [4:0]                   core_wb_rd,
  input  logic [`XLEN-1:0]             core_wb_data,
  input  logic                         cop_issue_valid,
  input  logic [4:0]                   cop_issue_rd,
  regfile_writeback_if.slave           cop_res,
  input  logic [4:0]                   rs1_address,
  input  logic [4:0]                   rs2_address,
  output logic                         hazard,
  output logic                         rf_write_enable,
  output logic [4:0]                   rf_rd_address,
  output logic [`XLEN-1:0]             rf_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  wb_entry_t    fifo_head;
  wb_entry_t    res_entry;
  wb_entry_t    sel_entry;
  logic         fifo_full;
  logic         fifo_empty;
  logic         accept;
  logic         push;
  logic         pop;
  logic         bypass;
  logic         sel_valid;
  logic [31:0]  busy;
  logic [31:0]  busy_next;

  // Ready depends only on the registered count, never on this cycle's pop
  assign cop_res.cop_res_ready = reset && !fifo_full;
  assign accept    = cop_res.cop_res_valid && cop_res.cop_res_ready;
  assign res_entry = '{rd: cop_res.cop_res_rd, data: cop_res.cop_res_data};
  assign push      = accept && !bypass;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (res_entry),
    .pop        (pop),
    .head_entry (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Source selection: core first, then FIFO head (then direct bypass)
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (core_wb_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: core_wb_rd, data: core_wb_data};
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_entry = fifo_head;
`ifdef WB_BYPASS_EN
    end else if (accept) begin
      bypass    = 1'b1;
      sel_valid = 1'b1;
      sel_entry = res_entry;
`endif
    end
  end

  // Clear before set so an issue to the same register in the same cycle wins
  always_comb begin
    busy_next = busy;
    if (pop || bypass) begin
      busy_next[sel_entry.rd] = 1'b0;
    end
    if (cop_issue_valid) begin
      busy_next[cop_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard = busy[rs1_address] | busy[rs2_address];

  // Writes to x0 are dropped; address/data hold when nothing is selected
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_rd_address   <= REG_ZERO;
      rf_rd_data      <= '0;
    end else begin
      rf_write_enable <= sel_valid && (sel_entry.rd != REG_ZERO);
      if (sel_valid) begin
        rf_rd_address <= sel_entry.rd;
        rf_rd_data    <= sel_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a reference model pushes the
// expected register-file write for every cycle into a queue, which is
// popped and compared right after each clock edge. A vector table covers
// priority and scoreboard behaviour; hand sequences cover full/wrap,
// mid-operation reset and the bypass latency.
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              core_wb_valid = 1'b0;
  logic [4:0]        core_wb_rd = '0;
  logic [`XLEN-1:0]  core_wb_data = '0;
  logic              cop_issue_valid = 1'b0;
  logic [4:0]        cop_issue_rd = '0;
  logic [4:0]        rs1_address = '0;
  logic [4:0]        rs2_address = '0;
  logic              hazard;
  logic              rf_write_enable;
  logic [4:0]        rf_rd_address;
  logic [`XLEN-1:0]  rf_rd_data;
  logic [2:0]        fifo_count;

  regfile_writeback_if cop_if ();

  regfile_writeback #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .core_wb_valid   (core_wb_valid),
    .core_wb_rd      (core_wb_rd),
    .core_wb_data    (core_wb_data),
    .cop_issue_valid (cop_issue_valid),
    .cop_issue_rd    (cop_issue_rd),
    .cop_res         (cop_if),
    .rs1_address     (rs1_address),
    .rs2_address     (rs2_address),
    .hazard          (hazard),
    .rf_write_enable (rf_write_enable),
    .rf_rd_address   (rf_rd_address),
    .rf_rd_data      (rf_rd_data),
    .fifo_count      (fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              we;
    logic [4:0]        rd;
    logic [`XLEN-1:0]  data;
  } exp_t;

  typedef struct {
    logic              core_v;
    logic [4:0]        core_rd;
    logic [`XLEN-1:0]  core_data;
    logic              cop_v;
    logic [4:0]        cop_rd;
    logic [`XLEN-1:0]  cop_data;
    logic              iss_v;
    logic [4:0]        iss_rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        exp_count;
    logic              exp_hazard;
  } vec_t;

  exp_t         exp_q[$];
  wb_entry_t    model_fifo[$];
  logic [31:0]  model_busy = '0;
  int           total = 0;
  int           bad = 0;
  vec_t         vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic core_v, input logic [4:0] core_rd,
                               input logic [`XLEN-1:0] core_data,
                               input logic cop_v, input logic [4:0] cop_rd,
                               input logic [`XLEN-1:0] cop_data,
                               input logic iss_v, input logic [4:0] iss_rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    core_wb_valid        = core_v;
    core_wb_rd           = core_rd;
    core_wb_data         = core_data;
    cop_if.cop_res_valid = cop_v;
    cop_if.cop_res_rd    = cop_rd;
    cop_if.cop_res_data  = cop_data;
    cop_issue_valid      = iss_v;
    cop_issue_rd         = iss_rd;
    rs1_address          = rs1;
    rs2_address          = rs2;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Reference model: evaluates the cycle about to be clocked with the
  // current inputs and queues the write expected right after the edge.
  function automatic void model_step();
    exp_t       e;
    wb_entry_t  sel;
    logic       sel_v;
    logic       accepted;
    logic       bypassed;
    e        = '{we: 1'b0, rd: 5'd0, data: '0};
    sel      = '0;
    sel_v    = 1'b0;
    bypassed = 1'b0;
    if (!reset) begin
      model_fifo.delete();
      model_busy = '0;
      exp_q.push_back(e);
      return;
    end
    accepted = cop_if.cop_res_valid && (model_fifo.size() < DEPTH);
    if (core_wb_valid) begin
      sel_v    = 1'b1;
      sel.rd   = core_wb_rd;
      sel.data = core_wb_data;
    end else if (model_fifo.size() > 0) begin
      sel   = model_fifo.pop_front();
      sel_v = 1'b1;
      model_busy[sel.rd] = 1'b0;
`ifdef WB_BYPASS_EN
    end else if (accepted) begin
      sel_v    = 1'b1;
      bypassed = 1'b1;
      sel.rd   = cop_if.cop_res_rd;
      sel.data = cop_if.cop_res_data;
      model_busy[sel.rd] = 1'b0;
`endif
    end
    if (accepted && !bypassed) begin
      model_fifo.push_back('{rd: cop_if.cop_res_rd, data: cop_if.cop_res_data});
    end
    if (cop_issue_valid) begin
      model_busy[cop_issue_rd] = 1'b1;
    end
    model_busy[0] = 1'b0;
    if (sel_v && sel.rd != 5'd0) begin
      e = '{we: 1'b1, rd: sel.rd, data: sel.data};
    end
    exp_q.push_back(e);
  endfunction

  task automatic clock_cycle();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      checkOutput("rf_write_enable", rf_write_enable, e.we);
      if (e.we) begin
        checkOutput("rf_rd_address", rf_rd_address, e.rd);
        checkOutput("rf_rd_data", rf_rd_data, e.data);
      end
    end
    checkOutput("fifo_count", fifo_count, model_fifo.size());
    checkOutput("cop_res_ready", cop_if.cop_res_ready,
                reset && (model_fifo.size() < DEPTH));
    checkOutput("hazard", hazard, model_busy[rs1_address] | model_busy[rs2_address]);
  endtask

  initial begin
    // core_v rd data | cop_v rd data | iss_v rd | rs1 rs2 | count hazard
    vecs[0] = '{1'b1, 5'd5, 'hDEADBEEF, 1'b0, 5'd0, '0,    1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 5'd0, 'h1234,     1'b0, 5'd0, '0,    1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 5'd0, '0,         1'b0, 5'd0, '0,    1'b1, 5'd9, 5'd9, 5'd0, 3'd0, 1'b1};
    vecs[3] = '{1'b1, 5'd3, 'h11,       1'b1, 5'd7, 'h22,  1'b0, 5'd0, 5'd9, 5'd0, 3'd1, 1'b1};
    vecs[4] = '{1'b0, 5'd0, '0,         1'b0, 5'd0, '0,    1'b0, 5'd0, 5'd9, 5'd0, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 5'd1, 'hA,        1'b1, 5'd9, 'h99,  1'b0, 5'd0, 5'd9, 5'd0, 3'd1, 1'b1};
    vecs[6] = '{1'b0, 5'd0, '0,         1'b0, 5'd0, '0,    1'b0, 5'd0, 5'd9, 5'd0, 3'd0, 1'b0};
    vecs[7] = '{1'b1, 5'd2, 'hB,        1'b1, 5'd9, 'h98,  1'b1, 5'd9, 5'd9, 5'd0, 3'd1, 1'b1};
    vecs[8] = '{1'b0, 5'd0, '0,         1'b0, 5'd0, '0,    1'b1, 5'd9, 5'd9, 5'd0, 3'd0, 1'b1};
    vecs[9] = '{1'b0, 5'd0, '0,         1'b0, 5'd0, '0,    1'b0, 5'd0, 5'd0, 5'd9, 3'd0, 1'b1};

    applyIdle();
    reset = 1'b0;
    clock_cycle();
    clock_cycle();
    checkOutput("reset_we", rf_write_enable, 1'b0);
    checkOutput("reset_addr", rf_rd_address, 5'd0);
    checkOutput("reset_data", rf_rd_data, '0);
    checkOutput("reset_ready", cop_if.cop_res_ready, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].core_v, vecs[i].core_rd, vecs[i].core_data,
                    vecs[i].cop_v, vecs[i].cop_rd, vecs[i].cop_data,
                    vecs[i].iss_v, vecs[i].iss_rd, vecs[i].rs1, vecs[i].rs2);
      clock_cycle();
      checkOutput($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
      checkOutput($sformatf("vec%0d_hazard", i), hazard, vecs[i].exp_hazard);
    end

    // Fill the FIFO while the core keeps the write port busy
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(20 + i), `XLEN'(32'h2000 + i), 1'b1, 5'(16 + i),
                    `XLEN'(32'h1600 + i), 1'b0, 5'd0, 5'd0, 5'd0);
      clock_cycle();
    end
    checkOutput("full_count", fifo_count, 3'd4);
    checkOutput("full_ready", cop_if.cop_res_ready, 1'b0);
    applyStimulus(1'b1, 5'd24, 'h2004, 1'b1, 5'd31, 'hBAD, 1'b0, 5'd0, 5'd0, 5'd0);
    clock_cycle();
    checkOutput("full_no_push", fifo_count, 3'd4);
    applyIdle();
    for (int i = 0; i < 4; i++) begin
      clock_cycle();
    end
    checkOutput("drained_count", fifo_count, 3'd0);
    // Six more results push the pointers past the wrap point
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'(10 + i), `XLEN'(32'hA000 + i),
                    1'b0, 5'd0, 5'd0, 5'd0);
      clock_cycle();
    end
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
    end

    // Reset in the middle of buffered traffic
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(25 + i), `XLEN'(32'h3000 + i), 1'b1, 5'(4 + i),
                    `XLEN'(32'h4000 + i), (i == 0), 5'd4, 5'd0, 5'd0);
      clock_cycle();
    end
    checkOutput("pre_reset_count", fifo_count, 3'd3);
    applyIdle();
    reset = 1'b0;
    clock_cycle();
    reset = 1'b1;
    rs1_address = 5'd4;
    #1;
    checkOutput("post_reset_count", fifo_count, 3'd0);
    checkOutput("post_reset_hazard", hazard, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
    end

    // Coprocessor result on an idle core with an empty FIFO
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd12, 'hC0FFEE, 1'b0, 5'd0, 5'd0, 5'd0);
    clock_cycle();
    applyIdle();
`ifdef WB_BYPASS_EN
    checkOutput("bypass_n1_we", rf_write_enable, 1'b1);
    checkOutput("bypass_n1_addr", rf_rd_address, 5'd12);
`else
    checkOutput("bypass_n1_we", rf_write_enable, 1'b0);
`endif
    clock_cycle();
`ifdef WB_BYPASS_EN
    checkOutput("bypass_n2_we", rf_write_enable, 1'b0);
`else
    checkOutput("bypass_n2_we", rf_write_enable, 1'b1);
    checkOutput("bypass_n2_addr", rf_rd_address, 5'd12);
`endif
    clock_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage directly upstream of the register file; drives its write port (write_enable, rd_address, rd_data).
- Merges two result sources:
  - single-cycle core datapath results, which always have priority;
  - multi-cycle AES coprocessor results, arriving on a valid/ready handshake and buffered in a small FIFO.
- Keeps a pending-destination scoreboard so the decoder can stall on read-after-write hazards against outstanding coprocessor results.

Parameters:
- FIFO_DEPTH, 4: coprocessor result buffer entries; power of two, >= 2.
- Data width is `XLEN (global macro), not a parameter.

Ports:
- clock  input  1  single clock domain, all state on posedge.
- reset  input  1  synchronous, active-low.
- core_wb_valid  input  1  core result present this cycle; no backpressure.
- core_wb_rd  input  5  core destination register.
- core_wb_data  input  `XLEN  core result.
- cop_issue_valid  input  1  coprocessor op issued; marks cop_issue_rd pending.
- cop_issue_rd  input  5  destination of the issued op.
- cop_res_valid  input  1  coprocessor result offered.
- cop_res_ready  output  1  result accepted when valid && ready.
- cop_res_rd  input  5  coprocessor result destination.
- cop_res_data  input  `XLEN  coprocessor result.
- rs1_address  input  5  decoder source 1.
- rs2_address  input  5  decoder source 2.
- hazard  output  1  rs1 or rs2 is pending (combinational).
- rf_write_enable  output  1  to regfile write_enable.
- rf_rd_address  output  5  to regfile rd_address.
- rf_rd_data  output  `XLEN  to regfile rd_data.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset == 0 at posedge):
  - rf_write_enable=0, rf_rd_address=0, rf_rd_data=0.
  - FIFO emptied, fifo_count=0, all 32 busy bits cleared.
  - cop_res_ready=0 while reset is low.
  - Reset mid-operation discards buffered results and pending marks; nothing is written afterwards.
- Arbitration, each cycle:
  - if core_wb_valid, select the core result;
  - else if the FIFO is non-empty, pop the head;
  - else select nothing.
- Output register: the selection is registered and presented on rf_* the next cycle. rf_write_enable=1 only if something was selected and rd != 0. rd == 0 writes are dropped, but a FIFO pop still occurs.
- Latency:
  - core valid at cycle N -> rf_write_enable at N+1.
  - coprocessor accepted at N -> earliest pop at N+1 -> rf_* at N+2.
- Starvation: core priority may starve the FIFO. This is accepted, because a stalled decoder inserts bubbles.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - cop_res_ready = (fifo_count < FIFO_DEPTH), using registered count only. When full, no push occurs even in a pop cycle.
  - A simultaneous push and pop leaves the count unchanged.
- Scoreboard, busy[31:1] (busy[0] is hardwired 0):
  - Set on cop_issue_valid for cop_issue_rd.
  - Cleared when a FIFO entry with that rd is popped.
  - Set and clear of the same register in the same cycle: set wins.
  - Core writes never touch busy; the decoder's hazard stall prevents WAW.
- hazard = busy[rs1_address] | busy[rs2_address]. It does not cover the 1-cycle window between the output register and the regfile write; the decoder handles that window.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when core_wb_valid=0, the FIFO is empty and cop_res_valid=1, the result goes straight to the output register with no push. Coprocessor latency becomes accept N -> rf_* N+1, and the busy bit is cleared at that capture.
- Undefined: every coprocessor result passes through the FIFO (2-cycle latency).

Decomposition:
- Package wb_pkg:
  - typedef wb_entry_t {logic [4:0] rd; logic [`XLEN-1:0] data;}
  - localparam REG_ZERO = 5'd0
  - default FIFO_DEPTH constant
- Sub-module wb_fifo:
  - parameterised FIFO of wb_entry_t with push/pop/full/empty/count;
  - contains all pointer wrap logic.

Test Plan:
- Core only: core_wb_valid=1, rd=5, data=0xDEADBEEF at cycle N -> rf_write_enable=1, rf_rd_address=5, rf_rd_data=0xDEADBEEF at N+1; rd=0 -> rf_write_enable=0.
- Priority: core (rd=3, 0x11) and a FIFO entry (rd=7, 0x22) present in the same cycle -> x3 written first, x7 the next idle cycle; fifo_count goes 1 -> 0.
- Full/wrap: hold core_wb_valid=1 and push 4 results (DEPTH=4) -> cop_res_ready=0 at count 4. Release core -> entries drain in order. Push 6 more -> correct order across pointer wrap.
- Scoreboard: issue rd=9, set rs1_address=9 -> hazard=1; result for x9 popped to output -> hazard=0 the same cycle busy clears. Issue and clear of x9 in the same cycle -> busy stays 1.
- Reset mid-operation: 3 entries buffered, busy[4]=1, reset low for 1 cycle -> fifo_count=0, hazard=0, no further writes.
- WB_BYPASS_EN: idle core, empty FIFO, result rd=12 accepted at N -> rf_* valid at N+1 (N+2 without the macro).
